// File: rtl/fft_bitrev_reorder_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_reorder_if
// Description : Sample-stream bundle for the FFT bit-reversal reorder buffer.
//               It carries the valid-only input stream and the valid/ready
//               output stream. Complex samples are packed as {re, im}, with re
//               in the upper DATA_W bits. Both parts are two's complement.
//   Signals   : valid_in   - input sample strobe (the block is always ready)
//               din        - input sample {re, im}
//               dout_valid - output sample available
//               dout_ready - downstream accepts the output sample
//               dout       - output sample {re, im}, natural order
//               dout_last  - high with the sample at index N-1
//   Modports  : master - producer/consumer side (drives inputs, ready)
//               slave  - reorder buffer side
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_bitrev_reorder_if #(
    parameter int DATA_W = 16
);
    logic                  valid_in;
    logic [2*DATA_W-1:0]   din;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [2*DATA_W-1:0]   dout;
    logic                  dout_last;

    modport master (
        output valid_in, din, dout_ready,
        input  dout_valid, dout, dout_last
    );

    modport slave (
        input  valid_in, din, dout_ready,
        output dout_valid, dout, dout_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_reorder
// Description : Ping-pong reorder buffer for the end of the FFT pipeline.
//               It collects a frame that arrives in bit-reversed order and
//               stores each sample at its bit-reversed address. It then plays
//               the frame out in natural order on a valid/ready stream. If
//               both banks are busy when a frame starts, the whole frame is
//               discarded and the sticky overflow flag is set.
//   Ports     : clk      - clock
//               rst_n    - asynchronous active-low reset
//               clear    - synchronous clear of counters, bank flags and
//                          overflow (the storage is not cleared)
//               bus      - sample streams (slave modport)
//               overflow - sticky: at least one input frame was discarded
//   Params    : DATA_W - width of each Re/Im part
//               LOGN   - log2 of the frame length (2..12)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
    parameter int DATA_W = 16,
    parameter int LOGN   = 10
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clear,
    fft_bitrev_reorder_if.slave    bus,
    output logic                   overflow
);
    localparam int             N      = 1 << LOGN;
    localparam logic [LOGN-1:0] C_LAST = {LOGN{1'b1}};

    // Two banks of flop storage. Only the write path below updates them.
    logic [2*DATA_W-1:0] r_mem [2][N];

    logic [1:0]      r_full;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [LOGN-1:0] r_wr_cnt;
    logic [LOGN-1:0] r_rd_cnt;
    logic            r_drop;
    logic            r_overflow;

    logic [LOGN-1:0] w_wr_addr;
    logic            w_frame_start;
    logic            w_drop_now;
    logic            w_wr_en;
    logic            w_wr_last;
    logic            w_rd_hs;
    logic            w_rd_last;
    logic [1:0]      w_full_nxt;

    // Bit-reversed write address.
    for (genvar i = 0; i < LOGN; i++) begin : g_bitrev
        assign w_wr_addr[i] = r_wr_cnt[LOGN-1-i];
    end

    assign w_frame_start = bus.valid_in && (r_wr_cnt == '0);
    // The drop decision is made only at frame start, from the registered full
    // flag. A bank that frees up in the same cycle, or later in the frame,
    // does not rescue the frame.
    assign w_drop_now    = w_frame_start ? r_full[r_wr_bank] : r_drop;
    assign w_wr_en       = bus.valid_in && !w_drop_now && !clear;
    assign w_wr_last     = bus.valid_in && (r_wr_cnt == C_LAST);

    assign w_rd_hs       = r_full[r_rd_bank] && bus.dout_ready;
    assign w_rd_last     = w_rd_hs && (r_rd_cnt == C_LAST);

    // Releasing one bank and completing the other can happen in the same
    // cycle. They never touch the same bank: a kept frame writes into an empty
    // bank, and an empty bank cannot be the one being read.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_last && !w_drop_now) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.valid_in) begin
                // Keep counting through dropped frames so frame alignment
                // with upstream is preserved.
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_frame_start) begin
                    r_drop <= w_drop_now;
                end
                if (w_wr_last) begin
                    if (w_drop_now) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_bank <= ~r_wr_bank;
                    end
                end
            end
            if (w_rd_hs) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
            r_full <= w_full_nxt;
        end
    end

    // The storage has no reset. Its contents are don't-care until a full
    // flag marks them valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][w_wr_addr] <= bus.din;
        end
    end

    assign bus.dout_valid = r_full[r_rd_bank];
    assign bus.dout       = r_mem[r_rd_bank][r_rd_cnt];
    assign bus.dout_last  = r_full[r_rd_bank] && (r_rd_cnt == C_LAST);
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bitrev_reorder
// Description : Scoreboard bench for fft_bitrev_reorder with LOGN=3.
//               Sample k of a frame with offset o is re=o+k, im=-(o+k).
//               Natural output index j carries input k=bitrev(j), so it
//               shows re = o + {0,4,2,6,1,5,3,7}[j].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;
    localparam int DATA_W = 16;
    localparam int LOGN   = 3;
    localparam int N      = 8;

    typedef struct packed {
        logic [2*DATA_W-1:0] data;
        logic                last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic overflow;

    fft_bitrev_reorder_if #(.DATA_W(DATA_W)) bus ();

    fft_bitrev_reorder #(.DATA_W(DATA_W), .LOGN(LOGN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus.slave),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   c_br [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [15:0] ready_pat = 16'b1011_0010_1101_0100;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [2*DATA_W-1:0] mk(input int v);
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        re = DATA_W'(v);
        im = DATA_W'(-v);
        return {re, im};
    endfunction

    // Drives one frame with no gap, one sample per cycle. valid_in is left
    // high so that consecutive calls form back-to-back frames. When the frame
    // is expected to be kept, its natural-order output goes on the scoreboard.
    task automatic send_frame(input int off, input bit keep, input int nsamp = N);
        if (keep) begin
            for (int j = 0; j < N; j++) begin
                q.push_back('{data: mk(off + c_br[j]), last: (j == N-1)});
            end
        end
        for (int k = 0; k < nsamp; k++) begin
            bus.valid_in = 1'b1;
            bus.din      = mk(off + k);
            @(posedge clk) #1;
        end
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        repeat (n) @(posedge clk) #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk) #1;
            n++;
        end
        chk(name, q.size(), 0);
        @(posedge clk) #1;
        chk({name, "_valid_low"}, bus.dout_valid, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk) #1;
        clear = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake. While stalled, it
    // also checks that dout and dout_last stay stable.
    logic                prev_stall = 1'b0;
    logic [2*DATA_W-1:0] prev_dout;
    logic                prev_last;
    always @(negedge clk) begin
        if (rst_n && bus.dout_valid) begin
            if (prev_stall) begin
                chk("stall_dout", bus.dout, prev_dout);
                chk("stall_last", bus.dout_last, prev_last);
            end
            if (bus.dout_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dout", bus.dout, e.data);
                    chk("dout_last", bus.dout_last, e.last);
                end
            end
        end
        prev_stall = rst_n && bus.dout_valid && !bus.dout_ready;
        prev_dout  = bus.dout;
        prev_last  = bus.dout_last;
    end

    initial begin
        logic [2*DATA_W-1:0] held;
        bus.valid_in   = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk) #1;

        // Reset state
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout_last", bus.dout_last, 0);
        chk("rst_overflow", overflow, 0);

        // Single frame: latency is one cycle after the last sample.
        send_frame(0, 1, N-1);
        bus.valid_in = 1'b1;
        bus.din      = mk(N-1);
        chk("lat_before", bus.dout_valid, 0);
        @(posedge clk) #1;
        bus.valid_in = 1'b0;
        chk("lat_after", bus.dout_valid, 1);
        wait_drain("single_frame");

        // Three gapless frames with ready held high.
        send_frame(0, 1);
        send_frame(100, 1);
        send_frame(200, 1);
        idle(1);
        wait_drain("gapless");
        chk("gapless_overflow", overflow, 0);

        // Stalled output: two frames are stored and the third is dropped.
        bus.dout_ready = 1'b0;
        send_frame(0, 1);
        send_frame(100, 1);
        chk("stall_pre_ovf", overflow, 0);
        send_frame(200, 0);
        idle(1);
        chk("stall_overflow", overflow, 1);
        chk("stall_valid", bus.dout_valid, 1);
        held = bus.dout;
        idle(3);
        chk("stall_hold", bus.dout, held);
        bus.dout_ready = 1'b1;
        wait_drain("stall_drain");
        do_clear();
        chk("clear_overflow_a", overflow, 0);

        // Output ready toggles in a fixed 50% pattern, one frame every 24 cycles.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    bus.dout_ready = ready_pat[i % 16];
                    @(posedge clk) #1;
                end
                bus.dout_ready = 1'b1;
            end
            begin
                for (int f = 0; f < 4; f++) begin
                    send_frame(1000 + 10*f, 1);
                    idle(16);
                end
            end
        join
        wait_drain("paced");
        chk("paced_overflow", overflow, 0);

        // A frame starts in the same cycle as the last read handshake of the
        // full bank. That frame is dropped, and the next frame is kept.
        bus.dout_ready = 1'b0;
        send_frame(0, 1);
        send_frame(100, 1);
        bus.valid_in   = 1'b0;
        bus.dout_ready = 1'b1;
        repeat (7) @(posedge clk) #1;
        send_frame(200, 0);
        chk("boundary_overflow", overflow, 1);
        send_frame(300, 1);
        idle(1);
        wait_drain("boundary");
        chk("boundary_sticky", overflow, 1);

        // Asynchronous reset in the middle of a frame.
        send_frame(700, 0, 5);
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_valid", bus.dout_valid, 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        send_frame(400, 1);
        idle(1);
        wait_drain("after_reset");

        // The same sequence using clear. Overflow is set first so that
        // clearing it can be checked.
        bus.dout_ready = 1'b0;
        send_frame(0, 0);
        send_frame(100, 0);
        send_frame(200, 0);
        send_frame(800, 0, 5);
        bus.valid_in = 1'b0;
        chk("pre_clear_overflow", overflow, 1);
        do_clear();
        chk("clear_overflow_b", overflow, 0);
        chk("clear_valid", bus.dout_valid, 0);
        bus.dout_ready = 1'b1;
        send_frame(500, 1);
        idle(1);
        wait_drain("after_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Ping-pong reorder buffer that sits after the last `fft_stage` in the FFT pipeline. It collects one full frame from the always-ready, valid-only butterfly stream, which arrives in bit-reversed index order, and writes each sample at its bit-reversed address. It then plays the frame out in natural order 0..N-1 on a valid/ready interface to the downstream consumer (bus-side result reader / DMA).

## Interface
- `DATA_W`, default 16: width of each Re/Im part.
- `LOGN`, default 10: log2 of frame length; N = 1<<LOGN; legal range 2..12.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous clear: counters, bank flags, overflow → reset state; storage contents untouched.
- `valid_in`  in  1  input sample strobe; the block is always ready.
- `din`  in  fft_pkg::complex_t (2×DATA_W)  input sample, Re/Im signed.
- `dout_valid`  out  1  output sample available.
- `dout_ready`  in  1  downstream accepts the sample.
- `dout`  out  fft_pkg::complex_t  output sample, natural order.
- `dout_last`  out  1  high with the sample at index N-1.
- `overflow`  out  1  sticky: at least one input frame was discarded.

## Operation
- Storage: two banks of N×(2·DATA_W) flops. Per bank: `full[b]` flag. Pointers: `wr_bank`, `rd_bank` (1 bit each), `wr_cnt`, `rd_cnt` (LOGN bits each).
- Write side, per `valid_in`:
  - Frame start is `valid_in` with `wr_cnt==0`. At frame start, `drop` latches `full[wr_bank]`, using the registered value.
  - If not dropping, write `din` to `bank[wr_bank][bitrev(wr_cnt)]`.
  - `wr_cnt` always increments and wraps at N-1, so frame alignment is kept even while dropping.
  - On the last sample (`wr_cnt==N-1`) of a kept frame: set `full[wr_bank]` and toggle `wr_bank`.
  - On the last sample of a dropped frame: set `overflow`. `wr_bank` and `full` are unchanged.
  - A dropped frame stays dropped even if its bank frees mid-frame.
- Read side:
  - `dout_valid = full[rd_bank]`.
  - `dout = bank[rd_bank][rd_cnt]`, combinational read of the flop array.
  - `dout_last = dout_valid && rd_cnt==N-1`.
  - On handshake (`dout_valid && dout_ready`): `rd_cnt++`.
  - On the handshake at `rd_cnt==N-1`: clear `full[rd_bank]`, toggle `rd_bank`, `rd_cnt` wraps to 0.
- States per bank: EMPTY/FILLING → FULL (last write) → draining (handshakes) → EMPTY (last handshake).
- Simultaneous events:
  - Write-completion on one bank and read-release on the other in the same cycle: both take effect.
  - Frame start on a bank whose last read handshake occurs in the same cycle: the frame is dropped (decided; registered flag).
- Bitrev: `bitrev(k)[i] = k[LOGN-1-i]`.
- `clear` has priority over all same-cycle events. After clear, a frame in flight upstream is treated as starting at its next `valid_in`; system software must issue clear only at a frame boundary.
- No arithmetic; data passes bit-exact.

## Timing
- Reset values: `dout_valid=0`, `dout_last=0`, `overflow=0`, `dout` = bank0[0] contents (don't-care, unspecified), `wr_bank=rd_bank=0`, counters 0, `full=0`.
- Latency: if the last input sample has `valid_in` at cycle t, `dout_valid` rises at t+1 with index 0 present.
- Throughput: one sample per cycle in both directions.
  - With `dout_ready` held high, the output streams N consecutive cycles.
  - Back-to-back input frames with no gaps are sustained without loss.
- `dout` and `dout_last` are held stable while `dout_valid && !dout_ready`.
- Reset mid-frame: everything returns to reset values asynchronously. The partial frame is lost and the next `valid_in` is sample 0.

## Test plan
- LOGN=3, single frame, inputs re=k, im=-k for k=0..7 with `dout_ready=1` → `dout.re` = 0,4,2,6,1,5,3,7 (im negated); `dout_valid` rises 1 cycle after the 8th input; `dout_last` on the 8th output only.
- LOGN=3, three gapless frames (values offset 0, 100, 200), `dout_ready=1` → all 24 outputs correct and in order, `overflow=0`.
- LOGN=3, `dout_ready=0`, send 3 frames → frames 1–2 stored, frame 3 dropped, `overflow=1` after its 8th sample. Raise ready → 16 outputs from frames 1–2 only; `dout` stays stable during stalls.
- LOGN=3, random `dout_ready` (50%) with continuous input frames at 1 frame per 24 cycles → no drops, every frame bit-exact.
- Boundary: frame 3 starts in the same cycle as the last read handshake of the full bank → frame 3 dropped, `overflow=1`; frame 4 accepted.
- `rst_n` pulse after 5 samples of a frame, then a full frame → only the new frame is output, correctly ordered. The same sequence with `clear` instead gives the same result, and `clear` also resets a set `overflow`.
